mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Byte-serial bus responder at the far end of the memory controller: serves one byte per cycle
//   to/from on-chip RAM and a small memory-mapped IO window (UART TX FIFO, RX holding byte, halt).
//   Sits between the memory controller's byte bus and the RAM array / UART, and drives
//   io_buffer_full back to the controller.
// PARAMETERS
//   RAM_ADDR_W     17        RAM size = 2**RAM_ADDR_W bytes, mapped at 0x00000
//   IO_BASE        32'h30000 base of the IO window (8 bytes: IO_BASE..IO_BASE+7)
//   TX_DEPTH       8         TX FIFO entries (power of 2, >=4)
// PORTS
//   clk_in         in   1   clock
//   rst_in         in   1   synchronous reset, active-high
//   rdy_in         in   1   global ready; 0 = freeze bus side effects
//   mem_en         in   1   bus-cycle qualifier; 0 = no read/write side effects this cycle
//   mem_addr       in   32  byte address from the controller
//   mem_write      in   8   write data byte
//   r_nw_in        in   1   1 = read, 0 = write
//   mem_read       out  8   read data byte, registered (valid the cycle after the address)
//   io_buffer_full out  1   TX FIFO near full; the controller must not start a new access
//   tx_data        out  8   FIFO head byte to the UART
//   tx_valid       out  1   FIFO not empty
//   tx_ready       in   1   UART accepts tx_data this cycle
//   rx_data        in   8   received byte
//   rx_valid       in   1   rx_data valid
//   rx_ready       out  1   holding register empty
//   halt_out       out  1   sticky; set by a write to IO_BASE+4
// BEHAVIOUR
//   - Reset: mem_read=0, io_buffer_full=0, tx_valid=0, rx_ready=1, halt_out=0, FIFO count=0,
//     pointers=0, RX holding empty. RAM contents are not reset.
//   - Bus access = rdy_in && mem_en. Decode per access:
//     RAM:  mem_addr < 2**RAM_ADDR_W; IO: IO_BASE <= mem_addr < IO_BASE+8; else unmapped.
//   - Read latency exactly 1 cycle: mem_read <= data at mem_addr, updated only on a read access;
//     holds its value otherwise. Unmapped read returns 8'h00.
//   - RAM write: byte written at the clock edge of the access cycle; a read of the same address
//     in the next cycle returns the new byte.
//   - IO map: +0 write: push mem_write into TX FIFO; +0 read: return RX byte (8'h00 if empty),
//     clear holding reg; +4 read: {6'b0, rx_avail, io_buffer_full}; +4 write: set halt_out
//     (data ignored); other offsets: read 8'h00, write ignored. Unmapped writes ignored.
//   - TX FIFO: tx_valid = (count != 0); tx_data = head, stable while tx_valid && !tx_ready.
//     Pop on tx_valid && tx_ready (runs regardless of rdy_in). Push and pop in the same cycle:
//     count unchanged; on an empty FIFO the pushed byte appears on tx_data the next cycle.
//     Pointers wrap modulo TX_DEPTH.
//   - io_buffer_full: registered, = (next count >= TX_DEPTH-2); margin for one in-flight push
//     plus flag latency. Push when count == TX_DEPTH: byte dropped, count unchanged.
//   - RX: accept when rx_valid && rx_ready; rx_ready = !rx_avail. A read of +0 in the same cycle
//     as an accept returns the old contents (or 8'h00 if empty), and the new byte is retained.
//   - rdy_in=0: no RAM/IO side effects, mem_read holds; TX drain and RX accept still proceed.
//   - Reset mid-operation: FIFO flushed, pending RX byte lost, halt_out cleared, same cycle.
// TESTING
//   1 Write 0xA5 to RAM 0x00010, then read 0x00010 next cycle -> mem_read=0xA5 one cycle after
//     the read address.
//   2 Hold tx_ready=0; write 0x41,0x42,... to 0x30000 -> io_buffer_full rises once count reaches
//     6 (TX_DEPTH=8); a 9th push is dropped; raising tx_ready drains 0x41.. in order, with
//     tx_valid low after the 8th pop.
//   3 Empty FIFO, tx_ready=1, push 0x55 -> tx_valid=1 / tx_data=0x55 next cycle, popped, count 0.
//   4 rx_valid with rx_data=0x7E -> rx_ready=0; read 0x30004 -> 0x02; read 0x30000 -> 0x7E,
//     then rx_ready=1.
//   5 Write to 0x30004 -> halt_out=1 and stays set; rst_in pulse -> halt_out=0, FIFO empty,
//     mem_read=0.
//   6 Read 0x25000 (unmapped) -> 0x00; write with mem_en=0 or rdy_in=0 -> RAM unchanged.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Byte-serial bus responder at the far end of the memory
//            controller. It serves one byte per cycle to/from on-chip RAM and
//            to/from a small memory-mapped IO window containing a UART TX FIFO,
//            an RX holding byte and a sticky halt flag.
//
// Memory map
//   0x00000 .. 2**RAM_ADDR_W-1 : RAM, byte wide
//   IO_BASE+0  wr : push byte into TX FIFO
//   IO_BASE+0  rd : RX holding byte (0x00 if empty), clears the holding reg
//   IO_BASE+4  wr : set halt_out (data ignored)
//   IO_BASE+4  rd : {6'b0, rx_avail, io_buffer_full}
//   other IO offsets read 0x00 and ignore writes; unmapped likewise
//
// Ports
//   clk_in          clock
//   rst_in          synchronous reset, active-high
//   rdy_in          global ready; 0 freezes bus side effects
//   mem_en          bus-cycle qualifier
//   mem_addr[31:0]  byte address
//   mem_write[7:0]  write data byte
//   r_nw_in         1 = read, 0 = write
//   mem_read[7:0]   registered read data (valid the cycle after the address)
//   io_buffer_full  registered TX FIFO near-full flag
//   tx_data[7:0]    TX FIFO head byte
//   tx_valid        TX FIFO not empty
//   tx_ready        UART accepts tx_data this cycle
//   rx_data[7:0]    received byte
//   rx_valid        rx_data valid
//   rx_ready        RX holding register empty
//   halt_out        sticky halt flag
//
// Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int          RAM_ADDR_W = 17,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000,
    parameter int          TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_en,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_write,
    input  logic        r_nw_in,
    output logic [7:0]  mem_read,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt_out
);

    localparam int PTR_W    = $clog2(TX_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int RAM_SIZE = 1 << RAM_ADDR_W;

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(TX_DEPTH);
    // Flag raised two entries early: one push may already be in flight when
    // the controller samples the flag, and the flag itself lags by a cycle.
    localparam logic [CNT_W-1:0] NEAR_FULL_CNT = CNT_W'(TX_DEPTH - 2);

    localparam logic [2:0] IO_OFF_DATA = 3'd0;
    localparam logic [2:0] IO_OFF_CTRL = 3'd4;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0] ram_mem [0:RAM_SIZE-1];
    logic [7:0] tx_mem  [0:TX_DEPTH-1];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [7:0]       mem_read_q, mem_read_d;
    logic             full_q,     full_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic             rx_avail_q, rx_avail_d;
    logic [7:0]       rx_hold_q,  rx_hold_d;
    logic             halt_q,     halt_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        w_access;
    logic        w_is_ram;
    logic        w_is_io;
    logic [31:0] w_io_off;
    logic        w_rd_acc;
    logic        w_wr_acc;
    logic        w_rd_data_io;
    logic        w_rd_ctrl_io;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_rx_accept;
    logic        w_halt_set;
    logic        w_ram_we;
    logic [7:0]  w_rd_data;

    assign w_access = rdy_in && mem_en;
    assign w_is_ram = ((mem_addr >> RAM_ADDR_W) == 32'd0);
    assign w_io_off = mem_addr - IO_BASE;
    // Upper offset bits must be zero so that the window is exactly 8 bytes.
    assign w_is_io  = (mem_addr >= IO_BASE) && (w_io_off[31:3] == 29'd0);

    assign w_rd_acc = w_access &&  r_nw_in;
    assign w_wr_acc = w_access && !r_nw_in;

    assign w_rd_data_io = w_rd_acc && w_is_io && (w_io_off[2:0] == IO_OFF_DATA);
    assign w_rd_ctrl_io = w_rd_acc && w_is_io && (w_io_off[2:0] == IO_OFF_CTRL);
    assign w_push_req   = w_wr_acc && w_is_io && (w_io_off[2:0] == IO_OFF_DATA);
    assign w_halt_set   = w_wr_acc && w_is_io && (w_io_off[2:0] == IO_OFF_CTRL);
    assign w_ram_we     = w_wr_acc && w_is_ram;

    // A push into a completely full FIFO is dropped even if a pop happens in
    // the same cycle; the controller is expected to honour io_buffer_full.
    assign w_push      = w_push_req && (count_q != FIFO_FULL_CNT);
    // Draining and receiving are independent of the bus ready.
    assign w_pop       = tx_valid && tx_ready;
    assign w_rx_accept = rx_valid && rx_ready;

    // ------------------------------------------------------------------
    // Read data multiplexer (registered into mem_read)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 8'h00;
        if (w_is_ram) begin
            w_rd_data = ram_mem[mem_addr[RAM_ADDR_W-1:0]];
        end else if (w_is_io) begin
            case (w_io_off[2:0])
                IO_OFF_DATA: w_rd_data = rx_avail_q ? rx_hold_q : 8'h00;
                IO_OFF_CTRL: w_rd_data = {6'b0, rx_avail_q, full_q};
                default:     w_rd_data = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_read_d = mem_read_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rx_avail_d = rx_avail_q;
        rx_hold_d  = rx_hold_q;
        halt_d     = halt_q;

        if (w_rd_acc) begin
            mem_read_d = w_rd_data;
        end

        // Pointers wrap naturally because TX_DEPTH is a power of two.
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

        full_d = (count_d >= NEAR_FULL_CNT);

        // An accept only happens while the holding reg is empty, so a
        // simultaneous read of the data register sees 0x00 and the new byte
        // must survive; accept therefore takes priority over the clear.
        if (w_rx_accept) begin
            rx_avail_d = 1'b1;
            rx_hold_d  = rx_data;
        end else if (w_rd_data_io) begin
            rx_avail_d = 1'b0;
        end

        if (w_halt_set) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_read_q <= 8'h00;
            full_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_avail_q <= 1'b0;
            rx_hold_q  <= 8'h00;
            halt_q     <= 1'b0;
        end else begin
            mem_read_q <= mem_read_d;
            full_q     <= full_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rx_avail_q <= rx_avail_d;
            rx_hold_q  <= rx_hold_d;
            halt_q     <= halt_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage arrays (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_ram_we) begin
            ram_mem[mem_addr[RAM_ADDR_W-1:0]] <= mem_write;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            tx_mem[wr_ptr_q] <= mem_write;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_read       = mem_read_q;
    assign io_buffer_full = full_q;
    assign tx_valid       = (count_q != '0);
    assign tx_data        = tx_mem[rd_ptr_q];
    assign rx_ready       = !rx_avail_q;
    assign halt_out       = halt_q;

    // The debug-only query of stuck ready inputs is not needed; every
    // rdy_in-gated effect is captured in w_access above.
    logic w_unused;
    assign w_unused = (RAM_SIZE == 0);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder. Inputs are
//            driven 1 time unit after the rising edge and outputs are checked
//            at the same point, i.e. after the registers have settled.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_write;
    logic        r_nw_in;
    logic [7:0]  mem_read;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt_out;

    int n_cmp;
    int n_err;

    mem_responder #(
        .RAM_ADDR_W (17),
        .IO_BASE    (32'h0003_0000),
        .TX_DEPTH   (8)
    ) u_dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_write      (mem_write),
        .r_nw_in        (r_nw_in),
        .mem_read       (mem_read),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .halt_out       (halt_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [7:0] data);
        mem_en    = 1'b1;
        r_nw_in   = 1'b0;
        mem_addr  = addr;
        mem_write = data;
        tick();
        mem_en    = 1'b0;
        r_nw_in   = 1'b1;
    endtask

    task automatic bus_rd(input logic [31:0] addr);
        mem_en   = 1'b1;
        r_nw_in  = 1'b1;
        mem_addr = addr;
        tick();
        mem_en   = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        mem_en    = 1'b0;
        mem_addr  = 32'h0;
        mem_write = 8'h00;
        r_nw_in   = 1'b1;
        tx_ready  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        #1;
        tick();
        tick();
        rst_in = 1'b0;

        // Reset state
        chk("rst_mem_read", {24'h0, mem_read}, 32'h00);
        chk("rst_full",     {31'h0, io_buffer_full}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("rst_halt",     {31'h0, halt_out}, 32'h0);

        // RAM write then read back next cycle
        bus_wr(32'h0001_0, 8'hA5);
        bus_rd(32'h0001_0);
        chk("ram_rd_a5", {24'h0, mem_read}, 32'hA5);
        tick();
        chk("ram_hold", {24'h0, mem_read}, 32'hA5);

        // Top RAM byte, and first address past RAM must not alias to 0x10
        bus_wr(32'h0001_FFFF, 8'h3C);
        bus_wr(32'h0002_0010, 8'hEE);
        bus_rd(32'h0001_FFFF);
        chk("ram_top", {24'h0, mem_read}, 32'h3C);
        bus_rd(32'h0002_0010);
        chk("past_ram_rd", {24'h0, mem_read}, 32'h00);
        bus_rd(32'h0001_0);
        chk("no_alias", {24'h0, mem_read}, 32'hA5);

        // Unmapped read
        bus_rd(32'h0002_5000);
        chk("unmapped_rd", {24'h0, mem_read}, 32'h00);

        // Suppressed writes: mem_en=0, then rdy_in=0
        mem_en = 1'b0; r_nw_in = 1'b0; mem_addr = 32'h10; mem_write = 8'h11;
        tick();
        rdy_in = 1'b0; mem_en = 1'b1; mem_write = 8'h22;
        tick();
        mem_en = 1'b0; r_nw_in = 1'b1; rdy_in = 1'b1;
        bus_rd(32'h0001_0);
        chk("wr_gated", {24'h0, mem_read}, 32'hA5);
        // Read with rdy_in=0 must leave mem_read alone
        rdy_in = 1'b0;
        bus_rd(32'h0002_5000);
        rdy_in = 1'b1;
        chk("rd_gated_hold", {24'h0, mem_read}, 32'hA5);

        // Push into empty FIFO with UART ready
        tx_ready = 1'b1;
        bus_wr(32'h0003_0000, 8'h55);
        chk("tx1_valid", {31'h0, tx_valid}, 32'h1);
        chk("tx1_data",  {24'h0, tx_data}, 32'h55);
        tick();
        chk("tx1_drained", {31'h0, tx_valid}, 32'h0);

        // Fill FIFO with UART stalled; flag at count>=6, 9th push dropped
        tx_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            bus_wr(32'h0003_0000, 8'(8'h40 + k));
            chk($sformatf("fill_full_%0d", k), {31'h0, io_buffer_full},
                (k >= 6) ? 32'h1 : 32'h0);
        end
        bus_rd(32'h0003_0004);
        chk("status_full", {24'h0, mem_read}, 32'h01);
        chk("tx_head_stall", {24'h0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid_%0d", i), {31'h0, tx_valid}, 32'h1);
            chk($sformatf("drain_data_%0d", i), {24'h0, tx_data}, 32'(8'h41 + i));
            tick();
        end
        chk("drain_empty", {31'h0, tx_valid}, 32'h0);
        chk("drain_full_clr", {31'h0, io_buffer_full}, 32'h0);
        tx_ready = 1'b0;

        // RX receive, status, read-and-clear
        rx_data = 8'h7E; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("rx_ready_low", {31'h0, rx_ready}, 32'h0);
        bus_rd(32'h0003_0004);
        chk("rx_status", {24'h0, mem_read}, 32'h02);
        bus_rd(32'h0003_0000);
        chk("rx_byte", {24'h0, mem_read}, 32'h7E);
        chk("rx_ready_high", {31'h0, rx_ready}, 32'h1);
        bus_rd(32'h0003_0000);
        chk("rx_empty_rd", {24'h0, mem_read}, 32'h00);

        // Accept and read of +0 in the same cycle: old (empty) value, new kept
        rx_data = 8'h99; rx_valid = 1'b1;
        bus_rd(32'h0003_0000);
        rx_valid = 1'b0;
        chk("rx_same_cyc_rd", {24'h0, mem_read}, 32'h00);
        chk("rx_same_cyc_rdy", {31'h0, rx_ready}, 32'h0);
        bus_rd(32'h0003_0000);
        chk("rx_retained", {24'h0, mem_read}, 32'h99);

        // Unused IO offset and just past the window
        bus_rd(32'h0001_FFFF);
        bus_rd(32'h0003_0002);
        chk("io_off2", {24'h0, mem_read}, 32'h00);
        bus_rd(32'h0001_FFFF);
        bus_rd(32'h0003_0008);
        chk("io_past", {24'h0, mem_read}, 32'h00);

        // Halt is sticky, then reset clears everything mid-operation
        bus_wr(32'h0003_0004, 8'h00);
        chk("halt_set", {31'h0, halt_out}, 32'h1);
        tick();
        tick();
        chk("halt_sticky", {31'h0, halt_out}, 32'h1);
        bus_wr(32'h0003_0000, 8'h77);
        rx_data = 8'h12; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        bus_rd(32'h0001_0);
        chk("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        chk("pre_rst_read", {24'h0, mem_read}, 32'hA5);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("rst2_halt",     {31'h0, halt_out}, 32'h0);
        chk("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst2_mem_read", {24'h0, mem_read}, 32'h00);
        chk("rst2_rx_ready", {31'h0, rx_ready}, 32'h1);
        // RAM survives reset
        bus_rd(32'h0001_0);
        chk("ram_after_rst", {24'h0, mem_read}, 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
